// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants used by the hazard/stall logic.
package pipeline_pkg;

  // Architectural register index (x0..x31)
  typedef logic [4:0] reg_idx_t;

  // Hard-wired zero register; never a real destination
  localparam reg_idx_t REG_X0 = 5'd0;

  // Default depth of the mul/div result pipeline
  localparam int DEFAULT_MAX_OUTSTANDING = 2;

  // Width of the in-flight counter (holds 0..7)
  localparam int OUTST_W = 3;

endpackage : pipeline_pkg

// File: rtl/hazard_stall_unit_scoreboard.sv
// Register scoreboard for multi-cycle (mul/div) destinations.
// Tracks which registers await a result and how many results are in flight.
module reg_scoreboard
  import pipeline_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_issue,      // a mul/div instruction issues this cycle
  input  logic               i_set_en,     // issuing instruction writes a real Rd
  input  reg_idx_t           i_set_rd,
  input  logic               i_clr_valid,  // a mul/div result writes back this cycle
  input  reg_idx_t           i_clr_rd,
  output logic [31:0]        o_pending,
  output logic [OUTST_W-1:0] o_outstanding
);

  logic [31:0]        r_pending;
  logic [31:0]        w_pending_next;
  logic [OUTST_W-1:0] r_outstanding;
  logic               w_clr_en;

  // Writeback to x0 frees a slot but has no scoreboard bit to clear
  assign w_clr_en = i_clr_valid && (i_clr_rd != REG_X0);

  // Per-bit next state: set has priority over clear, x0 is never pending
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_bit
      if (gi == 0) begin : g_x0
        assign w_pending_next[gi] = 1'b0;
      end else begin : g_xn
        assign w_pending_next[gi] =
          (i_set_en && (i_set_rd == reg_idx_t'(gi))) ? 1'b1 :
          (w_clr_en && (i_clr_rd == reg_idx_t'(gi))) ? 1'b0 :
          r_pending[gi];
      end
    end
  endgenerate

  // Pending-bit register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_next;
    end
  end

  // In-flight counter: issue and completion in the same cycle cancel out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outstanding <= '0;
    end else begin
      case ({i_issue, i_clr_valid})
        2'b10:   r_outstanding <= r_outstanding + OUTST_W'(1);
        2'b01:   r_outstanding <= r_outstanding - OUTST_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign o_pending     = r_pending;
  assign o_outstanding = r_outstanding;

  // A writeback needs something in flight to complete
  a_wb_needs_outstanding: assert property (
    @(posedge clk) disable iff (rst) i_clr_valid |-> (r_outstanding != '0));

  // A writeback to a real register must match a pending destination
  a_wb_needs_pending: assert property (
    @(posedge clk) disable iff (rst) w_clr_en |-> r_pending[i_clr_rd]);

endmodule : reg_scoreboard

// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard detection: stalls IF/ID and bubbles ID/EX for
// load-use and mul/div scoreboard hazards the forwarding paths cannot cover.
module hazard_stall_unit
  import pipeline_pkg::*;
#(
  parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
  parameter int CNT_W           = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ID_valid,
  input  reg_idx_t           ID_Rs1,
  input  reg_idx_t           ID_Rs2,
  input  logic               ID_uses_rs1,
  input  logic               ID_uses_rs2,
  input  logic               ID_is_store,
  input  reg_idx_t           ID_Rd,
  input  logic               ID_RegWrite,
  input  logic               ID_is_multicycle,
  input  logic               EX_MemRead,
  input  reg_idx_t           EX_Rd,
  input  logic               branch_flush,
  input  logic               mc_wb_valid,
  input  reg_idx_t           mc_wb_Rd,
  output logic               stall,
  output logic               bubble,
  output logic               mc_issue,
  output logic [31:0]        pending,
  output logic [OUTST_W-1:0] outstanding,
  output logic [CNT_W-1:0]   stall_count
);

  localparam logic [OUTST_W-1:0] MAX_CNT = OUTST_W'(MAX_OUTSTANDING);

  logic             w_load_use;
  logic             w_raw;
  logic             w_waw;
  logic             w_struct;
  logic             w_hazard;
  logic             w_stall;
  logic             w_issue;
  logic             w_set_en;
  logic [CNT_W-1:0] r_stall_count;

  // Load data reaches MEM->EX forwarding one cycle too late for a consumer in ID;
  // store data (Rs2) is picked up later by the MEM-stage forward, so it never stalls.
  assign w_load_use = EX_MemRead && (EX_Rd != REG_X0) &&
                      ((ID_uses_rs1 && (ID_Rs1 == EX_Rd)) ||
                       (ID_uses_rs2 && (ID_Rs2 == EX_Rd) && !ID_is_store));

  // Reading a register still owned by mul/div (completion is not bypassed)
  assign w_raw = (ID_uses_rs1 && (ID_Rs1 != REG_X0) && pending[ID_Rs1]) ||
                 (ID_uses_rs2 && (ID_Rs2 != REG_X0) && pending[ID_Rs2]);

  // Overwriting a register a mul/div result will later land in
  assign w_waw = ID_RegWrite && (ID_Rd != REG_X0) && pending[ID_Rd];

  // Mul/div unit has no free result slot
  assign w_struct = ID_is_multicycle && (outstanding == MAX_CNT);

  assign w_hazard = ID_valid && (w_load_use || w_raw || w_waw || w_struct);

  // A flushed ID instruction is dead, so it never needs to wait
  assign w_stall  = w_hazard && !branch_flush && !rst;
  assign w_issue  = ID_valid && ID_is_multicycle && !w_stall && !branch_flush && !rst;
  assign w_set_en = w_issue && ID_RegWrite && (ID_Rd != REG_X0);

  assign stall    = w_stall;
  assign bubble   = w_stall;
  assign mc_issue = w_issue;

  reg_scoreboard u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .i_issue       (w_issue),
    .i_set_en      (w_set_en),
    .i_set_rd      (ID_Rd),
    .i_clr_valid   (mc_wb_valid),
    .i_clr_rd      (mc_wb_Rd),
    .o_pending     (pending),
    .o_outstanding (outstanding)
  );

  // Saturating count of stalled cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign stall_count = r_stall_count;

endmodule : hazard_stall_unit
